// File: rtl/powlib_busarb.sv
// powlib_busarb: round-robin arbiter that shares one powlib bus write port
// among B_RQS requesters. Each grant lasts up to MAXHOLD beats. The granted
// requester's beats pass through one registered output stage.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   inaddrs/indatas   requester i's address/data at [B_AW*i+:B_AW] / [B_DW*i+:B_DW]
//   invlds/inrdys     per-requester valid/ready
//   outaddr/outdata   arbitrated beat (registered)
//   outvld/outrdy     output handshake
//   grant             one-hot current grant, zero while idle
//   gntcnts           per-requester accepted-beat counters (only when
//                     POWLIB_BUSARB_CNT_EN is defined)
//
// Build option: define POWLIB_BUSARB_CNT_EN to add the gntcnts counters.
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif

module powlib_busarb #(
  parameter int unsigned B_RQS   = 3,
  parameter int unsigned B_AW    = 32,
  parameter int unsigned B_DW    = 32+4+`POWLIB_OPW,
  parameter int unsigned MAXHOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [B_AW*B_RQS-1:0]   inaddrs,
  input  logic [B_DW*B_RQS-1:0]   indatas,
  input  logic [B_RQS-1:0]        invlds,
  output logic [B_RQS-1:0]        inrdys,
  output logic [B_AW-1:0]         outaddr,
  output logic [B_DW-1:0]         outdata,
  output logic                    outvld,
  input  logic                    outrdy,
  output logic [B_RQS-1:0]        grant
`ifdef POWLIB_BUSARB_CNT_EN
  ,output logic [32*B_RQS-1:0]    gntcnts
`endif
);

  localparam int unsigned PW = (B_RQS > 1) ? $clog2(B_RQS) : 1;
  localparam int unsigned HW = $clog2(MAXHOLD) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   nxt_ptr;
  logic [HW-1:0]   holdcnt;
  logic            found;
  int unsigned     idx;
  logic [B_AW-1:0] g_addr;
  logic [B_DW-1:0] g_data;
  logic            g_vld;
  logic            out_free;
  logic            accept;
  logic            release_g;

  // First requesting index at or after ptr, wrapping modulo B_RQS.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < B_RQS; i++) begin
      idx = (32'(ptr) + i) % B_RQS;
      if (!found && invlds[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  // Mux out the granted requester's beat.
  always_comb begin
    g_addr = '0;
    g_data = '0;
    g_vld  = 1'b0;
    for (int unsigned i = 0; i < B_RQS; i++) begin
      if (gidx == PW'(i)) begin
        g_addr = inaddrs[i*B_AW +: B_AW];
        g_data = indatas[i*B_DW +: B_DW];
        g_vld  = invlds[i];
      end
    end
  end

  // The single output entry can take a new beat when empty or draining.
  assign out_free  = ~outvld | outrdy;
  assign accept    = (state == GRANT) & g_vld & out_free;
  // Release on the last permitted beat, or when the granted requester drops valid.
  assign release_g = (state == GRANT) &
                     (accept ? (holdcnt == HW'(MAXHOLD-1)) : ~g_vld);
  assign nxt_ptr   = (gidx == PW'(B_RQS-1)) ? '0 : gidx + PW'(1);

  // Ready goes only to the granted requester, and only when the output can load.
  always_comb begin
    inrdys = '0;
    if (state == GRANT && out_free) inrdys = grant;
  end

  // Arbitration FSM and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      holdcnt <= '0;
      grant   <= '0;
      outvld  <= 1'b0;
      outaddr <= '0;
      outdata <= '0;
    end else begin
      if (out_free) begin
        outvld <= accept;
        if (accept) begin
          outaddr <= g_addr;
          outdata <= g_data;
        end
      end
      case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            gidx    <= sel;
            grant   <= B_RQS'(1) << sel;
            holdcnt <= '0;
          end
        end
        GRANT: begin
          if (accept) holdcnt <= holdcnt + HW'(1);
          if (release_g) begin
            grant <= '0;
            ptr   <= nxt_ptr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POWLIB_BUSARB_CNT_EN
  logic [31:0] cnts [B_RQS];

  // Accepted-beat counter per requester; wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < B_RQS; i++) cnts[i] <= '0;
    end else if (accept) begin
      cnts[gidx] <= cnts[gidx] + 32'd1;
    end
  end

  for (genvar gi = 0; gi < B_RQS; gi++) begin : g_cnt
    assign gntcnts[32*gi +: 32] = cnts[gi];
  end
`endif

endmodule

// File: tb/tb_powlib_busarb.sv
// Testbench for powlib_busarb. It drives directed traffic from per-requester
// queues. The expected output order goes into a scoreboard queue when the
// stimulus is built, and each output handshake is checked against it.
module tb_powlib_busarb;

  localparam int unsigned B_RQS   = 3;
  localparam int unsigned B_AW    = 32;
  localparam int unsigned B_DW    = 40;
  localparam int unsigned MAXHOLD = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [B_AW*B_RQS-1:0] inaddrs;
  logic [B_DW*B_RQS-1:0] indatas;
  logic [B_RQS-1:0]      invlds;
  logic [B_RQS-1:0]      inrdys;
  logic [B_AW-1:0]       outaddr;
  logic [B_DW-1:0]       outdata;
  logic                  outvld;
  logic                  outrdy;
  logic [B_RQS-1:0]      grant;
`ifdef POWLIB_BUSARB_CNT_EN
  logic [32*B_RQS-1:0]   gntcnts;
`endif

  powlib_busarb #(.B_RQS(B_RQS), .B_AW(B_AW), .B_DW(B_DW), .MAXHOLD(MAXHOLD)) dut (
    .clk(clk), .rst(rst),
    .inaddrs(inaddrs), .indatas(indatas), .invlds(invlds), .inrdys(inrdys),
    .outaddr(outaddr), .outdata(outdata), .outvld(outvld), .outrdy(outrdy),
    .grant(grant)
`ifdef POWLIB_BUSARB_CNT_EN
    ,.gntcnts(gntcnts)
`endif
  );

  always #5 clk = ~clk;

  logic [B_AW-1:0]  rq [B_RQS][$];
  logic [B_AW-1:0]  expq [$];
  logic [B_RQS-1:0] glog [$];
  int               blog [$];
  int               gaplog [$];
  int               nvec = 0;
  int               nfail = 0;
  int               cur_beats = 0;
  int               zero_run = 0;
  bit               seen_grant = 0;
  logic [B_RQS-1:0] prev_grant = '0;

  function automatic logic [B_DW-1:0] mkdata(input logic [B_AW-1:0] a);
    return {a ^ 32'hC3A5_5A3C, a[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(B_RQS); i++) begin
      if (rq[i].size() > 0) begin
        invlds[i] = 1'b1;
        inaddrs[i*B_AW +: B_AW] = rq[i][0];
        indatas[i*B_DW +: B_DW] = mkdata(rq[i][0]);
      end else begin
        invlds[i] = 1'b0;
      end
    end
  endtask

  // One clock: sample the handshakes before the edge, then check and update after it.
  task automatic tick();
    logic [B_RQS-1:0] acc;
    logic             oacc, hold, was_rst;
    logic [B_AW-1:0]  pa, ea;
    logic [B_DW-1:0]  pd;
    #1;
    was_rst = rst;
    acc  = invlds & inrdys;
    oacc = outvld & outrdy;
    hold = outvld & ~outrdy;
    pa   = outaddr;
    pd   = outdata;
    if (!was_rst) begin
      chk("rdy_only_granted", 64'(inrdys & ~grant), 64'd0);
      if (hold) chk("rdy_low_in_hold", 64'(inrdys), 64'd0);
    end
    @(posedge clk);
    #1;
    if (!was_rst) begin
      if (oacc) begin
        chk("beat_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          ea = expq.pop_front();
          chk("out_addr", 64'(pa), 64'(ea));
          chk("out_data", 64'(pd), 64'(mkdata(ea)));
        end
      end
      if (hold) begin
        chk("hold_vld", 64'(outvld), 64'd1);
        chk("hold_addr", 64'(outaddr), 64'(pa));
        chk("hold_data", 64'(outdata), 64'(pd));
      end
      for (int i = 0; i < int'(B_RQS); i++) begin
        if (acc[i]) begin
          void'(rq[i].pop_front());
          cur_beats++;
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        if (seen_grant) gaplog.push_back(zero_run);
        seen_grant = 1'b1;
        glog.push_back(grant);
        zero_run = 0;
      end
      if (grant == '0) begin
        zero_run++;
        if (prev_grant != '0) begin
          blog.push_back(cur_beats);
          cur_beats = 0;
        end
      end
    end
    prev_grant = grant;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    outrdy = 1'b1;
    for (int i = 0; i < int'(B_RQS); i++) rq[i].delete();
    expq.delete();
    drive();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_outvld", 64'(outvld), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_inrdys", 64'(inrdys), 64'd0);
    chk("rst_outaddr", 64'(outaddr), 64'd0);
    chk("rst_outdata", 64'(outdata), 64'd0);
    glog.delete();
    blog.delete();
    gaplog.delete();
    seen_grant = 1'b0;
    cur_beats = 0;
    zero_run = 0;
  endtask

  function automatic bit busy();
    bit b = (expq.size() != 0) || outvld || (grant != '0);
    for (int i = 0; i < int'(B_RQS); i++) if (rq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (busy() && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_drain_in_time"}, 64'(n < 300), 64'd1);
    chk({tag, "_scoreboard_empty"}, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [B_RQS-1:0] eg2 [6];
    int               eb2 [6];
    logic [B_RQS-1:0] eg4 [3];
    logic [B_AW-1:0]  a;

    rst = 1'b1;
    invlds = '0;
    inaddrs = '0;
    indatas = '0;
    outrdy = 1'b1;
    do_reset();

    // T1: single requester, two beats.
    rq[1].push_back(32'h5001_0000);
    rq[1].push_back(32'h5001_0004);
    expq.push_back(32'h5001_0000);
    expq.push_back(32'h5001_0004);
    drive();
    tick();
    chk("t1_grant_c1", 64'(grant), 64'b010);
    chk("t1_inrdys_c1", 64'(inrdys), 64'b010);
    chk("t1_outvld_c1", 64'(outvld), 64'd0);
    tick();
    chk("t1_outvld_c2", 64'(outvld), 64'd1);
    chk("t1_outaddr_c2", 64'(outaddr), 64'h5001_0000);
    tick();
    chk("t1_outvld_c3", 64'(outvld), 64'd1);
    chk("t1_outaddr_c3", 64'(outaddr), 64'h5001_0004);
    tick();
    chk("t1_grant_c4", 64'(grant), 64'd0);
    chk("t1_outvld_c4", 64'(outvld), 64'd0);
    drain("t1");

    // T2: all three request 6 beats each.
    do_reset();
    for (int b = 0; b < 6; b++)
      for (int r = 0; r < 3; r++)
        rq[r].push_back(32'h6000_0000 | (r << 8) | (b << 2));
    for (int r = 0; r < 3; r++)
      for (int b = 0; b < 4; b++) expq.push_back(32'h6000_0000 | (r << 8) | (b << 2));
    for (int r = 0; r < 3; r++)
      for (int b = 4; b < 6; b++) expq.push_back(32'h6000_0000 | (r << 8) | (b << 2));
    eg2 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    eb2 = '{4, 4, 4, 2, 2, 2};
    drive();
    drain("t2");
    chk("t2_ngrants", 64'(glog.size()), 64'd6);
    chk("t2_nbursts", 64'(blog.size()), 64'd6);
    chk("t2_ngaps", 64'(gaplog.size()), 64'd5);
    for (int i = 0; i < 6; i++) begin
      chk("t2_grant_seq", (i < glog.size()) ? 64'(glog[i]) : 64'hx, 64'(eg2[i]));
      chk("t2_beats", (i < blog.size()) ? 64'(blog[i]) : 64'hx, 64'(eb2[i]));
    end
    for (int i = 0; i < 5; i++)
      chk("t2_bubble", (i < gaplog.size()) ? 64'(gaplog[i]) : 64'hx, 64'd1);
`ifdef POWLIB_BUSARB_CNT_EN
    for (int i = 0; i < 3; i++) chk("t6_gntcnt", 64'(gntcnts[32*i +: 32]), 64'd6);
`endif

    // T3: backpressure mid-burst.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      a = 32'h7000_0000 + 32'(k * 4);
      rq[0].push_back(a);
      expq.push_back(a);
    end
    drive();
    tick();
    tick();
    outrdy = 1'b0;
    repeat (5) tick();
    chk("t3_hold_outvld", 64'(outvld), 64'd1);
    chk("t3_hold_addr", 64'(outaddr), 64'h7000_0000);
    chk("t3_hold_inrdys", 64'(inrdys), 64'd0);
    outrdy = 1'b1;
    drain("t3");

    // T4: early release after one beat; pointer advances to requester 1.
    do_reset();
    rq[0].push_back(32'h8000_0000);
    rq[1].push_back(32'h8000_0100);
    rq[1].push_back(32'h8000_0104);
    rq[2].push_back(32'h8000_0200);
    expq.push_back(32'h8000_0000);
    expq.push_back(32'h8000_0100);
    expq.push_back(32'h8000_0104);
    expq.push_back(32'h8000_0200);
    drive();
    tick();
    chk("t4_grant_c1", 64'(grant), 64'b001);
    tick();
    chk("t4_grant_c2", 64'(grant), 64'b001);
    tick();
    chk("t4_grant_c3", 64'(grant), 64'b000);
    tick();
    chk("t4_grant_c4", 64'(grant), 64'b010);
    drain("t4");
    eg4 = '{3'b001, 3'b010, 3'b100};
    chk("t4_ngrants", 64'(glog.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("t4_grant_seq", (i < glog.size()) ? 64'(glog[i]) : 64'hx, 64'(eg4[i]));

    // T5: reset while an output beat is pending.
    do_reset();
    for (int k = 0; k < 3; k++) rq[2].push_back(32'h9000_0200 + 32'(k * 4));
    drive();
    tick();
    chk("t5_grant_c1", 64'(grant), 64'b100);
    outrdy = 1'b0;
    tick();
    chk("t5_pending", 64'(outvld), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_outvld_after_rst", 64'(outvld), 64'd0);
    chk("t5_grant_after_rst", 64'(grant), 64'd0);
    chk("t5_inrdys_after_rst", 64'(inrdys), 64'd0);
    for (int i = 0; i < int'(B_RQS); i++) rq[i].delete();
    expq.delete();
    rq[0].push_back(32'h9000_0000);
    rq[2].push_back(32'h9000_0208);
    expq.push_back(32'h9000_0000);
    expq.push_back(32'h9000_0208);
    outrdy = 1'b1;
    drive();
    tick();
    chk("t5_restart_grant", 64'(grant), 64'b001);
    drain("t5");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
